// File: rtl/pipe_pkg.sv
// Shared definitions for the writeback skid stage: result-select encodings,
// writeback payload layout and the skid buffer occupancy states.
package pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

    // Field order here is the bit order used when the payload is flattened.
    typedef struct packed {
        logic [XLEN_DEF-1:0] read_data;
        logic [XLEN_DEF-1:0] alu_result;
        logic [XLEN_DEF-1:0] pc_plus4;
        logic [1:0]          result_src;
        logic                reg_write;
        logic [RD_W_DEF-1:0] rd;
    } wb_payload_t;

    function automatic int payload_width(input int xlen, input int rd_w);
        return 3 * xlen + 3 + rd_w;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer: main entry drives the output, skid entry
// absorbs one beat while the consumer stalls so ready_in stays registered.
module skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_reg;
    skid_state_e  state_next;
    logic [W-1:0] main_reg;
    logic [W-1:0] skid_reg;
    logic         accept;
    logic         deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            unique case (state_reg)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !deliver)      state_next = ST_FULL;
                    else if (!accept && deliver) state_next = ST_EMPTY;
                end
                ST_FULL:  if (deliver) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags decode only the state register, so they move on edges only.
    always_comb begin
        in_ready  = (state_reg != ST_FULL);
        out_valid = (state_reg != ST_EMPTY);
    end

    // Payload registers keep stale contents when their slot empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else if (!flush) begin
            unique case (state_reg)
                ST_EMPTY: if (accept) main_reg <= in_data;
                ST_ONE: begin
                    if (accept && deliver) main_reg <= in_data;
                    else if (accept)       skid_reg <= in_data;
                end
                ST_FULL:  if (deliver) main_reg <= skid_reg;
                default: ;
            endcase
        end
    end

    assign out_data = main_reg;

endmodule

// File: rtl/pipe_write_skid.sv
// Memory-to-writeback pipeline register with skid buffering and reg_write gating.
// Define PIPE_WRITE_RESULT_MUX_EN to add the combinational result_w select.
module pipe_write_skid
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            valid_m,
    output logic            ready_m,
    input  logic [XLEN-1:0] read_data_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [1:0]      result_src_m,
    input  logic            reg_write_m,
    input  logic [RD_W-1:0] rd_m,
    output logic            valid_w,
    input  logic            ready_w,
    output logic [XLEN-1:0] read_data_w,
    output logic [XLEN-1:0] alu_result_w,
    output logic [XLEN-1:0] pc_plus4_w,
    output logic [1:0]      result_src_w,
    output logic            reg_write_w,
    output logic [RD_W-1:0] rd_w
`ifdef PIPE_WRITE_RESULT_MUX_EN
    ,
    output logic [XLEN-1:0] result_w
`endif
);

    localparam int PW = payload_width(XLEN, RD_W);

    logic [PW-1:0] payload_m;
    logic [PW-1:0] payload_w;
    logic          reg_write_stored;

    assign payload_m = {read_data_m, alu_result_m, pc_plus4_m,
                        result_src_m, reg_write_m, rd_m};

    skid_buf #(
        .W(PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (valid_m),
        .in_ready  (ready_m),
        .in_data   (payload_m),
        .out_valid (valid_w),
        .out_ready (ready_w),
        .out_data  (payload_w)
    );

    assign {read_data_w, alu_result_w, pc_plus4_w,
            result_src_w, reg_write_stored, rd_w} = payload_w;

    // A stale entry left in main after delivery or flush must never write the register file.
    assign reg_write_w = reg_write_stored && valid_w;

`ifdef PIPE_WRITE_RESULT_MUX_EN
    always_comb begin
        result_w = '0;
        unique case (result_src_w)
            RES_ALU:  result_w = alu_result_w;
            RES_MEM:  result_w = read_data_w;
            RES_PC4:  result_w = pc_plus4_w;
            default:  result_w = '0;
        endcase
    end
`endif

endmodule
